// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit, one operation in flight.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
// Signed operations run on magnitudes; the sign is applied in FIX.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   i_start          request, accepted only in IDLE when i_flush is low
//   i_funct3         000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   i_op_a, i_op_b   rs1 / rs2 values, sampled only on the accepting edge
//   i_rd_in          destination register index, latched on accept
//   i_flush          synchronous abort of the in-flight operation
//   o_busy           high whenever the FSM is not IDLE
//   o_done           one-cycle pulse, o_result/o_rd_out valid (register-file write enable)
//   o_result         operation result, held until the next done
//   o_rd_out         destination index, held until the next done
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [4:0]      i_rd_in,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] L_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] L_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] L_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t              r_state;
  logic [2:0]          r_funct3;
  logic [4:0]          r_rd;
  logic [4:0]          r_cnt;
  // MUL: {partial sum, remaining multiplier bits}; DIV: {remainder, dividend/quotient}
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;   // multiplicand magnitude or divisor magnitude
  logic                r_neg_q; // negate product / quotient
  logic                r_neg_r; // negate remainder (sign of dividend)
  logic                r_fast;  // result already in r_acc low half

  logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_abs_a, w_abs_b, w_fast_val;
  logic                w_div_zero, w_ovf;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_div_shift;
  logic                w_div_ge;
  logic [XLEN-1:0]     w_div_sub, w_div_rem;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo, w_rem, w_fix;

  // Operand decode: signedness per funct3, magnitudes and fast-path detection
  always_comb begin
    w_a_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                 (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    w_b_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    w_a_neg    = w_a_signed && i_op_a[XLEN-1];
    w_b_neg    = w_b_signed && i_op_b[XLEN-1];
    w_abs_a    = w_a_neg ? f_neg(i_op_a) : i_op_a;
    w_abs_b    = w_b_neg ? f_neg(i_op_b) : i_op_b;
    w_div_zero = i_funct3[2] && (i_op_b == L_ZERO);
    w_ovf      = i_funct3[2] && !i_funct3[0] && (i_op_a == L_MIN) && (i_op_b == L_ONES);
    // funct3[1] separates REM* from DIV*
    if (w_div_zero) begin
      w_fast_val = i_funct3[1] ? i_op_a : L_ONES;
    end else begin
      w_fast_val = i_funct3[1] ? L_ZERO : L_MIN;
    end
  end

  // One iteration step of both datapaths; the FSM picks the one in use
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                  (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    // When the subtraction succeeds the difference is below the divisor, so XLEN bits suffice
    w_div_sub   = w_div_shift[XLEN-1:0] - r_opb;
    w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
    w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};
  end

  // Sign fix-up and result selection
  always_comb begin
    w_prod = r_neg_q ? f_neg2(r_acc) : r_acc;
    w_quo  = r_neg_q ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    w_rem  = r_neg_r ? f_neg(r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
    if (r_fast) begin
      w_fix = r_acc[XLEN-1:0];
    end else begin
      case (r_funct3)
        3'b000:                 w_fix = w_prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_fix = w_quo;
        3'b110, 3'b111:         w_fix = w_rem;
        default:                w_fix = L_ZERO;
      endcase
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'd0;
      r_rd     <= 5'd0;
      r_cnt    <= 5'd0;
      r_acc    <= {(2*XLEN){1'b0}};
      r_opb    <= L_ZERO;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_fast   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= L_ZERO;
      o_rd_out <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start && !i_flush) begin
            r_funct3 <= i_funct3;
            r_rd     <= i_rd_in;
            r_cnt    <= 5'd0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            o_busy   <= 1'b1;
            if (w_div_zero || w_ovf) begin
              r_fast  <= 1'b1;
              r_acc   <= {L_ZERO, w_fast_val};
              r_state <= S_FIX;
            end else begin
              r_fast  <= 1'b0;
              r_state <= S_CALC;
              if (i_funct3[2]) begin
                r_acc <= {L_ZERO, w_abs_a};
                r_opb <= w_abs_b;
              end else begin
                r_acc <= {L_ZERO, w_abs_b};
                r_opb <= w_abs_a;
              end
            end
          end
        end
        S_CALC: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            o_result <= w_fix;
            o_rd_out <= r_rd;
            o_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
